// File: rtl/ecc_job_sched.sv
// ecc_job_sched: round-robin job scheduler and APB master for the ECC core.
// Ports: two job requesters (reqN_*), one response channel (rsp_*), APB
// master (PADDR/PWDATA/PSEL/PENABLE/PWRITE) and core status inputs.
module ecc_job_sched #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 32,
  parameter logic [AMBA_ADDR_WIDTH-1:0] ADDR_CTRL     = 'h00,
  parameter logic [AMBA_ADDR_WIDTH-1:0] ADDR_DATA_IN  = 'h04,
  parameter logic [AMBA_ADDR_WIDTH-1:0] ADDR_CW_WIDTH = 'h08,
  parameter logic [AMBA_ADDR_WIDTH-1:0] ADDR_NOISE    = 'h0C,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [1:0]                 req0_mode,
  input  logic [1:0]                 req0_width,
  input  logic [DATA_WIDTH-1:0]      req0_data,
  input  logic [DATA_WIDTH-1:0]      req0_noise,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [1:0]                 req1_mode,
  input  logic [1:0]                 req1_width,
  input  logic [DATA_WIDTH-1:0]      req1_data,
  input  logic [DATA_WIDTH-1:0]      req1_noise,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_id,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [1:0]                 rsp_num_errors,
  output logic [1:0]                 rsp_status,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 num_of_errors
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_WAIT, S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic [1:0]            idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  id_q, id_d;
  logic [1:0]            mode_q, mode_d;
  logic [1:0]            width_q, width_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] noise_q, noise_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rerr_q, rerr_d;
  logic [1:0]            rstat_q, rstat_d;

  logic                  gnt0, gnt1;
  logic [1:0]            s_mode, s_width;
  logic                  in_apb;
  logic [AMBA_ADDR_WIDTH-1:0] paddr;
  logic [AMBA_WORD-1:0]  pwdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      idx_q   <= '0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      mode_q  <= '0;
      width_q <= '0;
      data_q  <= '0;
      noise_q <= '0;
      rdata_q <= '0;
      rerr_q  <= '0;
      rstat_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      mode_q  <= mode_d;
      width_q <= width_d;
      data_q  <= data_d;
      noise_q <= noise_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      rstat_q <= rstat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    mode_d  = mode_q;
    width_d = width_q;
    data_d  = data_q;
    noise_d = noise_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    rstat_d = rstat_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    s_mode  = gnt1 ? req1_mode : req0_mode;
    s_width = gnt1 ? req1_width : req0_width;
    unique case (state_q)
      S_IDLE: begin
        // Contention goes to whoever was not served last.
        gnt0    = req0_valid & (~req1_valid | last_q);
        gnt1    = req1_valid & (~req0_valid | ~last_q);
        s_mode  = gnt1 ? req1_mode : req0_mode;
        s_width = gnt1 ? req1_width : req0_width;
        if (gnt0 | gnt1) begin
          id_d    = gnt1;
          last_d  = gnt1;
          mode_d  = s_mode;
          width_d = s_width;
          data_d  = gnt1 ? req1_data : req0_data;
          noise_d = gnt1 ? req1_noise : req0_noise;
          if (s_mode == 2'd3 || s_width == 2'd3) begin
            rstat_d = 2'd1;
            rdata_d = '0;
            rerr_d  = '0;
            state_d = S_RESP;
          end else begin
            idx_d   = '0;
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          state_d = S_SETUP;
        end
      end
      S_WAIT: begin
        // Done takes priority over an expiring timeout.
        if (operation_done) begin
          rdata_d = data_out;
          rerr_d  = num_of_errors;
          rstat_d = 2'd0;
          state_d = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          rdata_d = '0;
          rerr_d  = '0;
          rstat_d = 2'd2;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register order: DATA_IN, CODEWORD_WIDTH, NOISE, then CTRL to start.
  always_comb begin
    paddr  = '0;
    pwdata = '0;
    unique case (idx_q)
      2'd0: begin
        paddr  = ADDR_DATA_IN;
        pwdata = AMBA_WORD'(data_q);
      end
      2'd1: begin
        paddr  = ADDR_CW_WIDTH;
        pwdata = AMBA_WORD'(width_q);
      end
      2'd2: begin
        paddr  = ADDR_NOISE;
        pwdata = AMBA_WORD'(noise_q);
      end
      default: begin
        paddr  = ADDR_CTRL;
        pwdata = AMBA_WORD'(mode_q);
      end
    endcase
  end

  assign in_apb  = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign PSEL    = in_apb;
  assign PWRITE  = in_apb;
  assign PENABLE = (state_q == S_ACCESS);
  assign PADDR   = in_apb ? paddr : '0;
  assign PWDATA  = in_apb ? pwdata : '0;

  assign req0_ready     = gnt0 & ~rst;
  assign req1_ready     = gnt1 & ~rst;
  assign rsp_valid      = (state_q == S_RESP);
  assign rsp_id         = id_q;
  assign rsp_data       = rdata_q;
  assign rsp_num_errors = rerr_q;
  assign rsp_status     = rstat_q;

endmodule
